// File: rtl/note_record_sequencer.sv
// Record-mode controller: turns key press/release edges into timestamped note RAM writes.
// Optional build macro NOTE_END_MARKER_EN appends a key-31 terminator entry when a take finishes.
module note_record_sequencer #(
  parameter int NUM_KEYS = 29,
  parameter int KEY_W    = 5,
  parameter int DELTA_W  = 27,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 1 + KEY_W + DELTA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [NUM_KEYS-1:0] key_state,
  input  logic                us_tick,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [ADDR_W:0]     event_count,
  output logic                recording,
  output logic                full,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } stateT;

  // One slot is reserved for the terminator when the marker is enabled.
`ifdef NOTE_END_MARKER_EN
  localparam logic [ADDR_W:0]  CAP     = (ADDR_W+1)'((2 ** ADDR_W) - 1);
  localparam logic [KEY_W-1:0] END_KEY = '1;
`else
  localparam logic [ADDR_W:0]  CAP     = (ADDR_W+1)'(2 ** ADDR_W);
`endif
  localparam logic [DELTA_W-1:0] DELTA_MAX = '1;

  stateT               stateReg, stateNext;
  logic [NUM_KEYS-1:0] snapshotReg, snapshotNext;
  logic [DELTA_W-1:0]  deltaReg, deltaNext;
  logic [ADDR_W:0]     countReg, countNext;
  logic                fullReg, fullNext;
  logic                wrEnReg, wrEnNext;
  logic [ADDR_W-1:0]   wrAddrReg, wrAddrNext;
  logic [DATA_W-1:0]   wrDataReg, wrDataNext;
  logic [NUM_KEYS-1:0] pending;
  logic [KEY_W-1:0]    keyIdx;

  // Lowest pending key wins; scanning downward leaves the lowest index last.
  always_comb begin
    pending = key_state ^ snapshotReg;
    keyIdx  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) keyIdx = KEY_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= IDLE;
      snapshotReg <= '0;
      deltaReg    <= '0;
      countReg    <= '0;
      fullReg     <= 1'b0;
      wrEnReg     <= 1'b0;
      wrAddrReg   <= '0;
      wrDataReg   <= '0;
    end else begin
      stateReg    <= stateNext;
      snapshotReg <= snapshotNext;
      deltaReg    <= deltaNext;
      countReg    <= countNext;
      fullReg     <= fullNext;
      wrEnReg     <= wrEnNext;
      wrAddrReg   <= wrAddrNext;
      wrDataReg   <= wrDataNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    snapshotNext = snapshotReg;
    deltaNext    = deltaReg;
    countNext    = countReg;
    fullNext     = fullReg;
    wrEnNext     = 1'b0;
    wrAddrNext   = wrAddrReg;
    wrDataNext   = wrDataReg;

    case (stateReg)
      IDLE, DONE: begin
        if (start) begin
          stateNext    = RECORD;
          snapshotNext = key_state;
          deltaNext    = '0;
          countNext    = '0;
          fullNext     = 1'b0;
        end
      end

      RECORD: begin
        if (us_tick && (deltaReg != DELTA_MAX)) deltaNext = deltaReg + 1'b1;
        if (|pending) begin
          wrEnNext             = 1'b1;
          wrAddrNext           = countReg[ADDR_W-1:0];
          wrDataNext           = {key_state[keyIdx], keyIdx, deltaReg};
          snapshotNext[keyIdx] = key_state[keyIdx];
          countNext            = countReg + 1'b1;
          // The tick arriving with the write belongs to the next interval.
          deltaNext            = DELTA_W'(us_tick);
          if (countNext == CAP) begin
            fullNext  = 1'b1;
            stateNext = FINISH;
          end
        end
        if (stop) stateNext = FINISH;
      end

      FINISH: begin
`ifdef NOTE_END_MARKER_EN
        wrEnNext   = 1'b1;
        wrAddrNext = countReg[ADDR_W-1:0];
        wrDataNext = {1'b0, END_KEY, deltaReg};
        countNext  = countReg + 1'b1;
`endif
        stateNext = DONE;
      end

      default: stateNext = IDLE;
    endcase
  end

  assign mem_wr_en   = wrEnReg;
  assign mem_wr_addr = wrAddrReg;
  assign mem_wr_data = wrDataReg;
  assign event_count = countReg;
  assign full        = fullReg;
  assign recording   = (stateReg == RECORD);
  assign done        = (stateReg == DONE);

endmodule

// File: tb/tb_note_record_sequencer.sv
// Bench for note_record_sequencer: directed scenarios plus random takes against a behavioural model.
// A second instance with a 4-bit delta field makes delta saturation reachable in a short run.
module tb_note_record_sequencer;

  localparam int  NK       = 29;
  localparam int  DW       = 27;
  localparam longint DMAX  = (64'd1 << DW) - 1;
`ifdef NOTE_END_MARKER_EN
  localparam bit  MARKER   = 1'b1;
  localparam int  CAP      = 127;
`else
  localparam bit  MARKER   = 1'b0;
  localparam int  CAP      = 128;
`endif

  logic          clk = 1'b0;
  logic          reset, start, stop, us_tick;
  logic [NK-1:0] key_state;
  logic          mem_wr_en, recording, full, done;
  logic [6:0]    mem_wr_addr;
  logic [32:0]   mem_wr_data;
  logic [7:0]    event_count;
  logic          sWrEn, sRecording, sFull, sDone;
  logic [6:0]    sWrAddr;
  logic [9:0]    sWrData;
  logic [7:0]    sCount;

  note_record_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .key_state(key_state),
    .us_tick(us_tick), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .event_count(event_count), .recording(recording),
    .full(full), .done(done)
  );

  note_record_sequencer #(.DELTA_W(4), .DATA_W(10)) dutSmall (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .key_state(key_state),
    .us_tick(us_tick), .mem_wr_en(sWrEn), .mem_wr_addr(sWrAddr),
    .mem_wr_data(sWrData), .event_count(sCount), .recording(sRecording),
    .full(sFull), .done(sDone)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: phase of the take, keys already logged, elapsed us, entries so far.
  localparam int PH_IDLE = 0, PH_REC = 1, PH_FIN = 2, PH_DONE = 3;
  int            mPhase;
  logic [NK-1:0] mLogged;
  longint        mElapsed;
  int            mCount;
  bit            mFull;
  bit            expWrEn;
  logic [6:0]    expAddr;
  logic [32:0]   expData;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    logic [NK-1:0] diff;
    int k;
    expWrEn = 1'b0;
    if (reset) begin
      mPhase = PH_IDLE; mLogged = '0; mElapsed = 0; mCount = 0; mFull = 1'b0;
      return;
    end
    case (mPhase)
      PH_IDLE, PH_DONE: if (start) begin
        mPhase = PH_REC; mLogged = key_state; mElapsed = 0; mCount = 0; mFull = 1'b0;
      end
      PH_REC: begin
        diff = key_state ^ mLogged;
        if (diff != '0) begin
          k = 0;
          for (int i = NK - 1; i >= 0; i--) if (diff[i]) k = i;
          expWrEn    = 1'b1;
          expAddr    = 7'(mCount);
          expData    = {key_state[k], 5'(k), mElapsed[26:0]};
          mLogged[k] = key_state[k];
          mCount     = mCount + 1;
          mElapsed   = us_tick ? 1 : 0;
          if (mCount == CAP) begin
            mFull  = 1'b1;
            mPhase = PH_FIN;
          end
        end else begin
          mElapsed = (mElapsed + (us_tick ? 1 : 0) > DMAX) ? DMAX : mElapsed + (us_tick ? 1 : 0);
        end
        if (stop) mPhase = PH_FIN;
      end
      default: begin
        if (MARKER) begin
          expWrEn = 1'b1;
          expAddr = 7'(mCount);
          expData = {1'b0, 5'd31, mElapsed[26:0]};
          mCount  = mCount + 1;
        end
        mPhase = PH_DONE;
      end
    endcase
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    check("wr_en", 64'(mem_wr_en), 64'(expWrEn));
    if (expWrEn) begin
      check("wr_addr", 64'(mem_wr_addr), 64'(expAddr));
      check("wr_data", 64'(mem_wr_data), 64'(expData));
    end
    check("event_count", 64'(event_count), 64'(mCount));
    check("flags rec/full/done", 64'({recording, full, done}),
          64'({mPhase == PH_REC, mFull, mPhase == PH_DONE}));
  endtask

  task automatic finishTake();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    reset = 1'b1; start = 1'b0; stop = 1'b0; us_tick = 1'b0; key_state = '0;
    #2;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset asserted between edges while a write is on the port.
    start = 1'b1;
    cycle();
    start = 1'b0;
    key_state = 29'h15;
    cycle();
    check("t1 wr_en before reset", 64'(mem_wr_en), 64'd1);
    reset = 1'b1;
    #1;
    check("t1 async wr_en", 64'(mem_wr_en), 64'd0);
    check("t1 async count", 64'(event_count), 64'd0);
    check("t1 async flags", 64'({recording, full, done}), 64'd0);
    cycle();
    reset = 1'b0;
    key_state = '0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    key_state = 29'h8;
    cycle();
    check("t1 first addr", 64'({mem_wr_en, mem_wr_addr}), 64'({1'b1, 7'd0}));
    finishTake();

    // Key 3 held at start is baseline; key 0 pressed after 5 us.
    start = 1'b1;
    cycle();
    start = 1'b0;
    us_tick = 1'b1;
    repeat (5) cycle();
    us_tick = 1'b0;
    key_state[0] = 1'b1;
    cycle();
    check("t2 data", 64'(mem_wr_data), 64'({1'b1, 5'd0, 27'd5}));
    repeat (3) cycle();
    finishTake();

    // Three simultaneous presses served lowest key first.
    start = 1'b1;
    cycle();
    start = 1'b0;
    us_tick = 1'b1;
    repeat (3) cycle();
    us_tick = 1'b0;
    key_state[2] = 1'b1; key_state[7] = 1'b1; key_state[28] = 1'b1;
    cycle();
    check("t3 write0", 64'(mem_wr_data), 64'({1'b1, 5'd2, 27'd3}));
    cycle();
    check("t3 write1", 64'(mem_wr_data), 64'({1'b1, 5'd7, 27'd0}));
    cycle();
    check("t3 write2", 64'(mem_wr_data), 64'({1'b1, 5'd28, 27'd0}));
    finishTake();

    // Long silence: the 4-bit instance saturates, the full-width one does not.
    start = 1'b1;
    cycle();
    start = 1'b0;
    us_tick = 1'b1;
    repeat (20) cycle();
    us_tick = 1'b0;
    key_state[1] = 1'b1;
    cycle();
    check("t4 full-width delta", 64'(mem_wr_data), 64'({1'b1, 5'd1, 27'd20}));
    check("t4 saturated delta", 64'({sWrEn, sWrData}), 64'({1'b1, 1'b1, 5'd1, 4'hF}));
    finishTake();

    // Fill the take to capacity with random toggles.
    start = 1'b1;
    cycle();
    start = 1'b0;
    steps = 0;
    while (mPhase != PH_DONE && steps < 600) begin
      key_state[$urandom_range(0, NK - 1)] ^= 1'b1;
      us_tick = 1'($urandom_range(0, 1));
      cycle();
      steps++;
    end
    us_tick = 1'b0;
    check("t5 reached done", 64'(steps < 600), 64'd1);
    check("t5 event_count", 64'(event_count), 64'd128);
    check("t5 full/done", 64'({full, done}), 64'({1'b1, 1'b1}));
    repeat (2) cycle();

    // Stop coinciding with a key 4 release.
    key_state[4] = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    key_state[4] = 1'b1;
    cycle();
    us_tick = 1'b1;
    repeat (2) cycle();
    us_tick = 1'b0;
    key_state[4] = 1'b0;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t6 release", 64'({mem_wr_en, mem_wr_data[32:27]}), 64'({1'b1, 1'b0, 5'd4}));
    cycle();
    check("t6 marker wr_en", 64'(mem_wr_en), 64'(MARKER));
    check("t6 done", 64'(done), 64'd1);
    repeat (2) cycle();

    // Random takes with stray start/stop pulses.
    for (int t = 0; t < 4; t++) begin
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 2) == 0) key_state[$urandom_range(0, NK - 1)] ^= 1'b1;
        us_tick = 1'($urandom_range(0, 1));
        start   = ($urandom_range(0, 9) == 0);
        stop    = ($urandom_range(0, 39) == 0);
        cycle();
      end
      start = 1'b0;
      us_tick = 1'b0;
      finishTake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
